// File: rtl/m68k_bus_target.sv
// 68000 asynchronous-bus target: 8 x 16-bit register window with programmable
// wait states, synchronised strobes and an open-drain DTACK.
module m68k_bus_target #(
  parameter logic [23:0] BASE_ADDR   = 24'hE90000,
  parameter int unsigned WAIT_STATES = 4
) (
  input  logic         SYSCLK,
  input  logic         nRESET,
  input  logic         nAS,
  input  logic         nUDS,
  input  logic         nLDS,
  input  logic         RnW,
  input  logic [23:1]  A_IN,
  input  logic [15:0]  D_IN,
  output logic [15:0]  D_OUT,
  output logic         D_OE,
  output logic         nDTACK_OUT,
  output logic         nDTACK_OE,
  output logic [127:0] REG_Q,
  output logic [15:0]  HIT_CNT
);

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT_DS,
    WAIT_CNT,
    ACK,
    IGNORE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        as_sync_q, as_sync_d;
  logic [1:0]        uds_sync_q, uds_sync_d;
  logic [1:0]        lds_sync_q, lds_sync_d;
  logic [1:0]        rw_sync_q, rw_sync_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [23:1]       addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [15:0]       hit_cnt_q, hit_cnt_d;
  logic              d_oe_q, d_oe_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              dtack_oe_q, dtack_oe_d;
  logic [1:0]        settle_q, settle_d;
  logic              armed_q, armed_d;

  logic              as_s, uds_s, lds_s, rw_s;
  logic              hit_c;
  logic [2:0]        idx_c;

  assign as_s  = as_sync_q[1];
  assign uds_s = uds_sync_q[1];
  assign lds_s = lds_sync_q[1];
  assign rw_s  = rw_sync_q[1];
  assign hit_c = (addr_q[23:4] == BASE_ADDR[23:4]);
  assign idx_c = addr_q[3:1];

  // State and data flops; synchronisers idle high so reset looks like "no strobe".
  always_ff @(posedge SYSCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= IDLE;
      as_sync_q  <= 2'b11;
      uds_sync_q <= 2'b11;
      lds_sync_q <= 2'b11;
      rw_sync_q  <= 2'b11;
      cnt_q      <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b1;
      regs_q     <= '{default: '0};
      hit_cnt_q  <= '0;
      d_oe_q     <= 1'b0;
      d_out_q    <= '0;
      dtack_oe_q <= 1'b0;
      settle_q   <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      as_sync_q  <= as_sync_d;
      uds_sync_q <= uds_sync_d;
      lds_sync_q <= lds_sync_d;
      rw_sync_q  <= rw_sync_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      regs_q     <= regs_d;
      hit_cnt_q  <= hit_cnt_d;
      d_oe_q     <= d_oe_d;
      d_out_q    <= d_out_d;
      dtack_oe_q <= dtack_oe_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    as_sync_d  = {as_sync_q[0], nAS};
    uds_sync_d = {uds_sync_q[0], nUDS};
    lds_sync_d = {lds_sync_q[0], nLDS};
    rw_sync_d  = {rw_sync_q[0], RnW};
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    regs_d     = regs_q;
    hit_cnt_d  = hit_cnt_q;
    d_oe_d     = d_oe_q;
    d_out_d    = d_out_q;
    dtack_oe_d = dtack_oe_q;
    settle_d   = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    // A cycle already in flight at reset release is only honoured after nAS goes high.
    armed_d    = armed_q | ((settle_q == 2'd2) & as_s);

    unique case (state_q)
      IDLE: begin
        d_oe_d     = 1'b0;
        d_out_d    = '0;
        dtack_oe_d = 1'b0;
        if (!as_s) begin
          addr_d  = A_IN;
          rw_d    = rw_s;
          state_d = armed_q ? DECODE : IGNORE;
        end
      end
      DECODE: begin
        if (as_s) begin
          state_d = IDLE;
        end else if (!hit_c) begin
          state_d = IGNORE;
        end else if (rw_q) begin
          state_d = WAIT_CNT;
          d_oe_d  = 1'b1;
          d_out_d = regs_q[idx_c];
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = WAIT_DS;
        end
      end
      WAIT_DS: begin
        if (as_s) begin
          state_d = IDLE;
        end else if (!uds_s || !lds_s) begin
          state_d = WAIT_CNT;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT_CNT: begin
        if (as_s) begin
          state_d = IDLE;
          d_oe_d  = 1'b0;
          d_out_d = '0;
        end else if (cnt_q == '0) begin
          state_d    = ACK;
          dtack_oe_d = 1'b1;
          hit_cnt_d  = hit_cnt_q + 16'd1;
          if (!rw_q) begin
            if (!uds_s) regs_d[idx_c][15:8] = D_IN[15:8];
            if (!lds_s) regs_d[idx_c][7:0]  = D_IN[7:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        if (as_s) begin
          state_d    = IDLE;
          d_oe_d     = 1'b0;
          d_out_d    = '0;
          dtack_oe_d = 1'b0;
        end
      end
      IGNORE: begin
        d_oe_d     = 1'b0;
        d_out_d    = '0;
        dtack_oe_d = 1'b0;
        if (as_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign REG_Q[DATA_W*g +: DATA_W] = regs_q[g];
  end

  assign D_OUT      = d_out_q;
  assign D_OE       = d_oe_q;
  assign nDTACK_OUT = 1'b0;
  assign nDTACK_OE  = dtack_oe_q;
  assign HIT_CNT    = hit_cnt_q;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Scoreboard bench for m68k_bus_target: bus accesses driven as a 68000 master would.
module tb_m68k_bus_target;

  localparam logic [23:0] BASE     = 24'hE90000;
  localparam int unsigned WS       = 4;
  // two synchroniser edges before as_s is low, then WAIT_STATES+3
  localparam int          READ_LAT = 2 + WS + 3;

  logic         SYSCLK, nRESET, nAS, nUDS, nLDS, RnW;
  logic [23:1]  A_IN;
  logic [15:0]  D_IN, D_OUT, HIT_CNT;
  logic         D_OE, nDTACK_OUT, nDTACK_OE;
  logic [127:0] REG_Q;

  int           total = 0;
  int           bad   = 0;
  logic [15:0]  model [8];
  logic [15:0]  rd_q [$];
  logic [15:0]  exp_hits;

  m68k_bus_target #(.BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .SYSCLK(SYSCLK), .nRESET(nRESET), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS),
    .RnW(RnW), .A_IN(A_IN), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
    .nDTACK_OUT(nDTACK_OUT), .nDTACK_OE(nDTACK_OE), .REG_Q(REG_Q), .HIT_CNT(HIT_CNT)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog expired");
  end

  // One complete bus cycle; expectations are queued when the cycle is driven.
  task automatic access(input logic [23:0] addr, input logic rnw, input logic [15:0] wdata,
                        input logic u, input logic l, input string name);
    logic        hit;
    logic [2:0]  idx;
    logic [15:0] exp_rd;
    int          lat, rel;
    bit          quiet, held;
    hit = (addr[23:4] == BASE[23:4]);
    idx = addr[3:1];
    lat = -1; rel = -1; quiet = 1'b1; held = 1'b1; exp_rd = '0;
    @(negedge SYSCLK);
    A_IN = addr[23:1]; D_IN = wdata; RnW = rnw; nAS = 1'b0; nUDS = ~u; nLDS = ~l;
    if (hit) begin
      exp_hits = exp_hits + 16'd1;
      if (rnw) rd_q.push_back(model[idx]);
      else begin
        if (u) model[idx][15:8] = wdata[15:8];
        if (l) model[idx][7:0]  = wdata[7:0];
      end
    end
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge SYSCLK);
      if (!hit && (D_OE || nDTACK_OE)) quiet = 1'b0;
      if (nDTACK_OE) lat = k;
    end
    if (hit) begin
      total++;
      if (lat < 0) begin
        bad++; $display("FAIL %s dtack_timeout: got none, want dtack within 40 cycles", name);
      end
      if (rnw) begin
        exp_rd = rd_q.pop_front();
        total++;
        if (lat != READ_LAT) begin
          bad++; $display("FAIL %s read_latency: got %0d want %0d", name, lat, READ_LAT);
        end
        total++;
        if (D_OE !== 1'b1 || D_OUT !== exp_rd) begin
          bad++; $display("FAIL %s read_data: got oe=%b d=%h want oe=1 d=%h", name, D_OE, D_OUT, exp_rd);
        end
      end else begin
        total++;
        if (D_OE !== 1'b0) begin
          bad++; $display("FAIL %s write_oe: got %b want 0", name, D_OE);
        end
      end
      repeat (3) begin
        @(negedge SYSCLK);
        if (nDTACK_OE !== 1'b1) held = 1'b0;
      end
      total++;
      if (!held) begin
        bad++; $display("FAIL %s dtack_hold: got dropped while nAS low, want held", name);
      end
    end else begin
      total++;
      if (!quiet || lat >= 0) begin
        bad++; $display("FAIL %s miss_quiet: got bus driven, want oe and dtack 0", name);
      end
    end
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    for (int k = 1; k <= 10 && rel < 0; k++) begin
      @(negedge SYSCLK);
      if (!D_OE && !nDTACK_OE) rel = k;
    end
    if (hit) begin
      total++;
      if (rel < 2 || rel > 3) begin
        bad++; $display("FAIL %s release: got %0d cycles want 2..3", name, rel);
      end
    end
    total++;
    if (D_OUT !== 16'h0 || D_OE !== 1'b0 || nDTACK_OE !== 1'b0) begin
      bad++; $display("FAIL %s idle_outputs: got d=%h oe=%b dt=%b want 0/0/0", name, D_OUT, D_OE, nDTACK_OE);
    end
    total++;
    if (HIT_CNT !== exp_hits) begin
      bad++; $display("FAIL %s hit_cnt: got %0d want %0d", name, HIT_CNT, exp_hits);
    end
  endtask

  task automatic test_reset();
    nRESET = 1'b0; nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; RnW = 1'b1; A_IN = '0; D_IN = '0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    exp_hits = '0;
    repeat (2) @(negedge SYSCLK);
    total++;
    if ({D_OE, nDTACK_OE, nDTACK_OUT} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000", {D_OE, nDTACK_OE, nDTACK_OUT});
    end
    total++;
    if (D_OUT !== 16'h0) begin bad++; $display("FAIL reset_dout: got %h want 0", D_OUT); end
    total++;
    if (REG_Q !== 128'h0) begin bad++; $display("FAIL reset_regs: got %h want 0", REG_Q); end
    total++;
    if (HIT_CNT !== 16'h0) begin bad++; $display("FAIL reset_hits: got %h want 0", HIT_CNT); end
    nRESET = 1'b1;
    repeat (5) @(negedge SYSCLK);
    total++;
    if ({D_OE, nDTACK_OE} !== 2'b00) begin
      bad++; $display("FAIL post_reset_idle: got %b want 00", {D_OE, nDTACK_OE});
    end
  endtask

  task automatic test_word_write();
    access(24'hE90004, 1'b0, 16'hBEEF, 1'b1, 1'b1, "word_write");
    total++;
    if (REG_Q[47:32] !== 16'hBEEF) begin bad++; $display("FAIL word_write_reg2: got %h want beef", REG_Q[47:32]); end
    total++;
    if (HIT_CNT !== 16'd1) begin bad++; $display("FAIL word_write_hits: got %0d want 1", HIT_CNT); end
  endtask

  task automatic test_byte_write();
    access(24'hE90006, 1'b0, 16'h1234, 1'b1, 1'b1, "byte_setup");
    access(24'hE90007, 1'b0, 16'hFF5A, 1'b0, 1'b1, "byte_lds");
    total++;
    if (REG_Q[63:48] !== 16'h125A) begin bad++; $display("FAIL byte_lds_reg3: got %h want 125a", REG_Q[63:48]); end
    access(24'hE90006, 1'b0, 16'hC3FF, 1'b1, 1'b0, "byte_uds");
    total++;
    if (REG_Q[63:48] !== 16'hC35A) begin bad++; $display("FAIL byte_uds_reg3: got %h want c35a", REG_Q[63:48]); end
  endtask

  task automatic test_read();
    access(24'hE90004, 1'b1, 16'h0000, 1'b1, 1'b1, "read_beef");
    access(24'hE90006, 1'b1, 16'h0000, 1'b0, 1'b1, "read_lds_only");
    access(24'hE90006, 1'b1, 16'h0000, 1'b1, 1'b0, "read_uds_only");
  endtask

  task automatic test_miss();
    access(24'hE90010, 1'b1, 16'h0000, 1'b1, 1'b1, "miss_read");
    access(24'hE8FFF4, 1'b0, 16'hDEAD, 1'b1, 1'b1, "miss_write");
    for (int i = 0; i < 8; i++) begin
      total++;
      if (REG_Q[16*i +: 16] !== model[i]) begin
        bad++; $display("FAIL miss_regs[%0d]: got %h want %h", i, REG_Q[16*i +: 16], model[i]);
      end
    end
  endtask

  // nAS withdrawn mid-cycle: once while counting wait states, once while waiting for a strobe.
  task automatic test_abort();
    bit quiet;
    for (int v = 0; v < 2; v++) begin
      quiet = 1'b1;
      @(negedge SYSCLK);
      A_IN = 23'h748004; D_IN = 16'h1111; RnW = 1'b0; nAS = 1'b0;
      nUDS = (v == 0) ? 1'b0 : 1'b1; nLDS = nUDS;
      repeat (4) begin @(negedge SYSCLK); if (nDTACK_OE || D_OE) quiet = 1'b0; end
      nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
      repeat (12) begin @(negedge SYSCLK); if (nDTACK_OE || D_OE) quiet = 1'b0; end
      total++;
      if (!quiet) begin bad++; $display("FAIL abort%0d_dtack: got dtack/oe, want none", v); end
      total++;
      if (REG_Q[79:64] !== model[4]) begin
        bad++; $display("FAIL abort%0d_reg4: got %h want %h", v, REG_Q[79:64], model[4]);
      end
      total++;
      if (HIT_CNT !== exp_hits) begin
        bad++; $display("FAIL abort%0d_hits: got %0d want %0d", v, HIT_CNT, exp_hits);
      end
    end
    access(24'hE90008, 1'b0, 16'h2222, 1'b1, 1'b1, "after_abort_wr");
    access(24'hE90008, 1'b1, 16'h0000, 1'b1, 1'b1, "after_abort_rd");
  endtask

  task automatic test_back_to_back();
    logic [1:0]  st;
    logic [15:0] data;
    for (int i = 0; i < 8; i++) begin
      st = 2'($urandom_range(1, 3));
      data = 16'($urandom);
      access({20'hE9000, 3'(i), 1'b0}, 1'b0, data, st[1], st[0], "b2b_wr");
    end
    for (int i = 7; i >= 0; i--) begin
      st = 2'($urandom_range(1, 3));
      access({20'hE9000, 3'(i), 1'b0}, 1'b1, 16'h0000, st[1], st[0], "b2b_rd");
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (REG_Q[16*i +: 16] !== model[i]) begin
        bad++; $display("FAIL b2b_regs[%0d]: got %h want %h", i, REG_Q[16*i +: 16], model[i]);
      end
    end
  endtask

  task automatic test_reset_mid_ack();
    int lat;
    bit quiet;
    logic [15:0] exp_rd;
    lat = -1; quiet = 1'b1;
    @(negedge SYSCLK);
    A_IN = 23'h748002; RnW = 1'b1; nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
    rd_q.push_back(model[2]);
    exp_hits = exp_hits + 16'd1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge SYSCLK);
      if (nDTACK_OE) lat = k;
    end
    exp_rd = rd_q.pop_front();
    total++;
    if (lat < 0 || D_OUT !== exp_rd) begin
      bad++; $display("FAIL rst_ack_read: got lat=%0d d=%h want ack d=%h", lat, D_OUT, exp_rd);
    end
    @(negedge SYSCLK);
    #2 nRESET = 1'b0;
    #1;
    total++;
    if ({D_OE, nDTACK_OE} !== 2'b00) begin
      bad++; $display("FAIL rst_async_release: got %b want 00", {D_OE, nDTACK_OE});
    end
    total++;
    if (REG_Q !== 128'h0 || D_OUT !== 16'h0 || HIT_CNT !== 16'h0) begin
      bad++; $display("FAIL rst_async_clear: got regs=%h d=%h hits=%h want 0", REG_Q, D_OUT, HIT_CNT);
    end
    for (int i = 0; i < 8; i++) model[i] = '0;
    exp_hits = '0;
    @(negedge SYSCLK);
    nRESET = 1'b1;
    repeat (12) begin @(negedge SYSCLK); if (D_OE || nDTACK_OE) quiet = 1'b0; end
    total++;
    if (!quiet) begin bad++; $display("FAIL rst_stale_cycle: got dtack/oe, want ignored"); end
    nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    repeat (4) @(negedge SYSCLK);
    access(24'hE9000C, 1'b0, 16'hA55A, 1'b1, 1'b1, "post_rst_wr");
    access(24'hE9000C, 1'b1, 16'h0000, 1'b1, 1'b1, "post_rst_rd");
    total++;
    if (REG_Q[111:96] !== 16'hA55A || HIT_CNT !== 16'd2) begin
      bad++; $display("FAIL post_rst_state: got reg6=%h hits=%0d want a55a 2", REG_Q[111:96], HIT_CNT);
    end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_write();
    test_read();
    test_miss();
    test_abort();
    test_back_to_back();
    test_reset_mid_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
